// File: rtl/pulse_gen_multi.sv
// Multi-channel edge-to-pulse generator: every lane turns a selected input edge
// into a same-cycle pulse, stretched to PULSE_LEN cycles and optionally held.
module pulse_gen_lane #(
  parameter int EDGE_MODE = 0,
  parameter int PULSE_LEN = 1,
  parameter int RETRIGGER = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  input  logic hold_i,
  output logic pulse_o,
  output logic missed_o
);
  localparam int CW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_LEN - 1);

  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_q, hold_d;
  logic          missed_q, missed_d;
  logic          rise, fall, edge_det, active, busy, accept;

  always_comb begin
    rise     = sig_i & ~prev_q;
    fall     = ~sig_i & prev_q;
    edge_det = (EDGE_MODE == 0) ? rise : (EDGE_MODE == 1) ? fall : (rise | fall);
    active   = (EDGE_MODE == 0) ? sig_i : (EDGE_MODE == 1) ? ~sig_i : 1'b1;
    busy     = (cnt_q != '0);
    accept   = (RETRIGGER != 0) ? edge_det : (edge_det & ~busy);

    prev_d   = sig_i;
    cnt_d    = cnt_q;
    if (accept)    cnt_d = RELOAD;
    else if (busy) cnt_d = cnt_q - CW'(1);

    // Set wins over clear; in both-edge mode any other edge drops the hold.
    hold_d = hold_q;
    if (accept & hold_i)                  hold_d = 1'b1;
    else if (~hold_i | ~active)           hold_d = 1'b0;
    else if ((EDGE_MODE == 2) & edge_det) hold_d = 1'b0;

    missed_d = edge_det & busy & (RETRIGGER == 0);
    pulse_o  = ~rst_i & (accept | busy | (hold_q & hold_i & active));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      hold_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      missed_q <= missed_d;
    end
  end

  assign missed_o = missed_q;
endmodule

module pulse_gen_multi #(
  parameter int CHANNELS  = 4,
  parameter int EDGE_MODE = 0,
  parameter int PULSE_LEN = 1,
  parameter int RETRIGGER = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] signal_in_i,
  input  logic [CHANNELS-1:0] hold_i,
  output logic [CHANNELS-1:0] pulse_out_o,
  output logic [CHANNELS-1:0] missed_o
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pulse_gen_lane #(
      .EDGE_MODE(EDGE_MODE),
      .PULSE_LEN(PULSE_LEN),
      .RETRIGGER(RETRIGGER)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .sig_i   (signal_in_i[c]),
      .hold_i  (hold_i[c]),
      .pulse_o (pulse_out_o[c]),
      .missed_o(missed_o[c])
    );
  end
endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: six configurations side by side, a cycle-level
// model based on accepted-edge timestamps, plus hand-computed directed checks.
module tb_pulse_gen_multi;
  localparam int NI = 6;
  localparam int CH = 4;
  localparam int MODE [NI] = '{0, 0, 0, 1, 2, 0};
  localparam int PLEN [NI] = '{1, 4, 4, 1, 1, 8};
  localparam int RTRG [NI] = '{1, 1, 0, 1, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst  [NI];
  logic [CH-1:0] sig  [NI];
  logic [CH-1:0] hold [NI];
  logic [CH-1:0] pout [NI];
  logic [CH-1:0] miss [NI];

  int n_run  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pulse_gen_multi #(
      .CHANNELS (CH),
      .EDGE_MODE(MODE[g]),
      .PULSE_LEN(PLEN[g]),
      .RETRIGGER(RTRG[g])
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst[g]),
      .signal_in_i(sig[g]),
      .hold_i     (hold[g]),
      .pulse_out_o(pout[g]),
      .missed_o   (miss[g])
    );
  end

  task automatic chk(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a lane is stretching while fewer than PULSE_LEN cycles have passed
  // since its last accepted edge; hold and missed follow the lane rules.
  int cyc = 0;
  bit m_prev  [NI][CH];
  bit m_arm   [NI][CH];
  bit m_miss  [NI][CH];
  bit m_vld   [NI][CH];
  int m_start [NI][CH];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [CH-1:0] ep, em;
      ep = '0;
      em = '0;
      for (int c = 0; c < CH; c++) begin
        bit s, h, rise, fall, e, act, busy, acc;
        s  = sig[i][c];
        h  = hold[i][c];
        em[c] = m_miss[i][c];
        if (rst[i]) begin
          m_prev[i][c] = 0; m_arm[i][c] = 0; m_miss[i][c] = 0; m_vld[i][c] = 0;
        end else begin
          rise = s & !m_prev[i][c];
          fall = !s & m_prev[i][c];
          e    = (MODE[i] == 0) ? rise : (MODE[i] == 1) ? fall : (rise | fall);
          act  = (MODE[i] == 0) ? s : (MODE[i] == 1) ? !s : 1'b1;
          busy = m_vld[i][c] && ((cyc - m_start[i][c]) < PLEN[i]);
          acc  = e && (RTRG[i] != 0 || !busy);
          ep[c] = acc || busy || (m_arm[i][c] && h && act);
          if (acc) begin m_start[i][c] = cyc; m_vld[i][c] = 1; end
          if (acc && h) m_arm[i][c] = 1;
          else if (!h || !act) m_arm[i][c] = 0;
          else if (MODE[i] == 2 && e) m_arm[i][c] = 0;
          m_miss[i][c] = e && busy && (RTRG[i] == 0);
          m_prev[i][c] = s;
        end
      end
      if (chk_en) begin
        chk($sformatf("model_pulse u%0d", i), pout[i], ep);
        chk($sformatf("model_missed u%0d", i), miss[i], em);
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] mix [16] = '{8'h01, 8'h13, 8'h37, 8'h36, 8'h2C, 8'h08, 8'hF9, 8'hFF,
                           8'hF0, 8'h05, 8'h5A, 8'hA5, 8'h0F, 8'h0E, 8'h00, 8'h81};
  logic [4:0] s3 = 5'b10011;
  logic [4:0] e3 = 5'b00100;
  logic [4:0] s4 = 5'b00110;
  logic [4:0] e4 = 5'b01010;

  initial begin
    for (int i = 0; i < NI; i++) begin rst[i] = 1'b1; sig[i] = '0; hold[i] = '0; end
    step();
    chk_en = 1'b1;
    step();

    // Inputs high during reset, then release: every lane sees a rise.
    for (int k = 0; k < 3; k++) begin
      step(); sig[0] = '1; #1 chk("p1_in_reset", pout[0], 4'h0);
    end
    step(); for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    #1 chk("p1_release", pout[0], 4'hF);
    step(); #1 chk("p1_steady", pout[0], 4'h0);
    step(); sig[0] = 4'hB; #1 chk("p1_ch2_low", pout[0], 4'h0);
    step(); sig[0] = 4'hF; #1 chk("p1_ch2_rise", pout[0], 4'h4);
    step(); sig[0] = 4'h0; #1 chk("p1_fall", pout[0], 4'h0);

    // Stretch with retrigger (u1) vs. ignore-and-flag (u2).
    for (int t = 0; t < 18; t++) begin
      logic s;
      step();
      s = (t == 10) || (t >= 12);
      sig[1] = {3'b0, s};
      sig[2] = {3'b0, s};
      #1;
      if (t >= 9 && t <= 16) begin
        chk($sformatf("p2_retrig t%0d", t), {3'b0, pout[1][0]}, {3'b0, (t >= 10 && t <= 15)});
        chk($sformatf("p2_noretrig t%0d", t), {3'b0, pout[2][0]}, {3'b0, (t >= 10 && t <= 13)});
        chk($sformatf("p2_missed t%0d", t), {3'b0, miss[2][0]}, {3'b0, (t == 13)});
      end
    end
    step(); sig[1] = '0; sig[2] = '0;

    // Hold on lane 1 of u0: latched at the edge, not latched when late.
    for (int t = 0; t < 14; t++) begin
      logic s, h;
      step();
      s = (t >= 5 && t <= 9) || (t >= 11);
      h = (t >= 5 && t <= 8) || (t >= 12 && t <= 13);
      sig[0]  = {2'b0, s, 1'b0};
      hold[0] = {2'b0, h, 1'b0};
      #1;
      if (t >= 4)
        chk($sformatf("p3_hold t%0d", t), pout[0],
            {2'b0, ((t >= 5 && t <= 8) || t == 11), 1'b0});
    end
    step(); sig[0] = '0; hold[0] = '0;

    // Falling mode (u3) and both-edge mode (u4).
    for (int t = 0; t < 5; t++) begin
      step();
      sig[3] = {CH{s3[t]}};
      sig[4] = (t < 4) ? {CH{s4[t]}} : '0;
      #1;
      chk($sformatf("p4_fall t%0d", t), pout[3], {CH{e3[t]}});
      if (t < 4) chk($sformatf("p4_both t%0d", t), pout[4], {CH{e4[t]}});
    end

    // Reset on the third stretch cycle, then a fresh rise on release.
    for (int t = 0; t < 13; t++) begin
      step();
      sig[5] = 4'h1;
      rst[5] = (t == 2);
      #1 chk($sformatf("p5_rst t%0d", t), {3'b0, pout[5][0]},
             {3'b0, (t < 2 || (t >= 3 && t <= 10))});
    end

    // Mixed lane activity on every configuration, checked by the model only.
    for (int t = 0; t < 16; t++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        sig[i]  = mix[t][3:0] ^ CH'(i);
        hold[i] = mix[t][7:4];
      end
    end
    for (int t = 0; t < 10; t++) begin
      step();
      for (int i = 0; i < NI; i++) begin sig[i] = '0; hold[i] = '0; end
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pulse_gen_multi.md
Name: pulse_gen_multi

Overview:
Parametrised, multi-channel successor to the single-channel pulse generator. Each channel detects a configurable edge (rise, fall or both) on its input. It emits a pulse on the same cycle as the edge, stretched to PULSE_LEN cycles. The pulse can optionally be held while that channel's hold input is asserted at the edge. Used in front of FIFO pop/request logic and handshake blocks that need one request per input event across several independent lanes.

Parameters:
CHANNELS, 4, number of independent channels (>=1)
EDGE_MODE, 0, 0 = rising, 1 = falling, 2 = both edges (applies to all channels)
PULSE_LEN, 1, minimum pulse width in cycles (>=1)
RETRIGGER, 1, 1 = an edge during a stretch reloads the counter; 0 = an edge during a stretch is ignored and flagged

Ports:
clk_i  input  1  clock; all state updates on posedge
rst_i  input  1  synchronous reset, active-high
signal_in_i  input  CHANNELS  per-channel input level, synchronous to clk_i
hold_i  input  CHANNELS  per-channel hold request; sampled at the edge
pulse_out_o  output  CHANNELS  per-channel output pulse
missed_o  output  CHANNELS  registered one-cycle flag: edge ignored (RETRIGGER=0 only)

Behaviour:
- One clock, synchronous active-high reset (rst_i). No asynchronous logic.
- Per-channel state:
  - prev[c]: registered copy of signal_in_i[c]
  - cnt[c]: width $clog2(PULSE_LEN+1)
  - hold_latched[c]
  - missed[c]
- Reset: prev=0, cnt=0, hold_latched=0, missed_o=0. pulse_out_o forced to 0 in any cycle where rst_i=1.
- Edge terms (combinational):
  - rise = sig & ~prev
  - fall = ~sig & prev
  - edge = rise (mode 0) | fall (mode 1) | rise|fall (mode 2)
- Active level:
  - active = sig (mode 0)
  - active = ~sig (mode 1)
  - active = 1 (mode 2)
- busy = (cnt != 0).
- accept:
  - RETRIGGER=1: accept = edge
  - RETRIGGER=0: accept = edge & ~busy
- pulse_out_o[c] = accept | busy | (hold_latched & hold_i[c] & active).
  - Zero-cycle latency from edge to output; the edge cycle counts as pulse cycle 1.
- Counter:
  - on accept: cnt <= PULSE_LEN-1
  - else if busy: cnt <= cnt-1
  - PULSE_LEN=1 gives a single-cycle pulse with the counter always 0.
- Hold latch (priority order):
  - set when accept & hold_i[c]
  - else cleared when ~hold_i[c] | ~active
  - mode 2: also cleared by any edge that does not set it
  - The output hold term is gated by live hold_i, so the output drops on the same cycle hold_i falls (pulse stretch still applies).
- missed_o[c] <= edge & busy & (RETRIGGER==0); always 0 when RETRIGGER=1.
- Reset-related boundaries:
  - An input already high at reset release produces a rise on the first cycle (mode 0/2).
  - Mid-operation reset clears stretch and hold immediately.
- Channels are fully independent; no shared state or arbitration.
- Width rule: PULSE_LEN must fit cnt; the counter never wraps (reloads only on accept, decrements only when nonzero).

Test Plan:
1. Reset and rising edge: CHANNELS=4, EDGE_MODE=0, PULSE_LEN=1. Hold rst_i 3 cycles with inputs high -> outputs 0. Release -> all 4 pulse 1 cycle. Ch2 toggles 0->1 -> single-cycle pulse on ch2 only, same cycle.
2. Stretch and retrigger: PULSE_LEN=4, RETRIGGER=1.
   - Ch0 rise at t=10 -> high t=10..13.
   - Second rise at t=12 -> high through t=15.
   - With RETRIGGER=0, same stimulus -> high t=10..13 and missed_o[0]=1 at t=13 (registered).
3. Hold: EDGE_MODE=0, PULSE_LEN=1, hold_i[1]=1 at rise on t=5, input stays high -> output high until hold_i drops at t=9 (low at t=9). Hold asserted only after the edge (t=6) -> 1-cycle pulse, no latch.
4. Falling/both modes:
   - EDGE_MODE=1: 1->0 -> pulse; 0->1 -> none.
   - EDGE_MODE=2: input 0,1,1,0 -> pulses on cycles 1 and 3 only.
5. Reset mid-stretch: PULSE_LEN=8, rst_i at 3rd stretch cycle -> output 0 that cycle. After release with input unchanged high -> a new pulse (prev cleared to 0).
